// File: rtl/data_register.sv
// Parallel-load data register with load enable and asynchronous active-low clear.
// Optional DATA_REGISTER_VALID_EN adds a sticky dout_valid flag set by the first load.
module data_register #(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 0
) (
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] dout
`ifdef DATA_REGISTER_VALID_EN
  ,
  output logic             dout_valid
`endif
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] dout_q;
  logic             load_en;

  // An unknown load must never capture: only a solid 1 enables the write.
  assign load_en = (load === 1'b1);

  always_comb begin
    dout_d = dout_q;
    if (load_en) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout_q <= RST_VAL;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef DATA_REGISTER_VALID_EN
  logic dout_valid_d;
  logic dout_valid_q;

  always_comb begin
    dout_valid_d = dout_valid_q;
    if (load_en) begin
      dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout_valid = dout_valid_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset === 1'b1) begin
      assert (!$isunknown(load))
      else $warning("data_register: load is X/Z at clock edge, holding dout");
    end
  end
`endif

endmodule

// File: tb/tb_data_register.sv
// Directed bench for data_register: reset, load, hold, mid-cycle reset and optional valid flag.
module tb_data_register;

  logic [7:0] din;
  logic       load;
  logic       clock;
  logic       reset;
  logic [7:0] dout;
`ifdef DATA_REGISTER_VALID_EN
  logic       dout_valid;
`endif

  int checks   = 0;
  int failures = 0;

  data_register #(.WIDTH(8), .RESET_VALUE(0)) dut (
    .din        (din),
    .load       (load),
    .clock      (clock),
    .reset      (reset),
    .dout       (dout)
`ifdef DATA_REGISTER_VALID_EN
    ,
    .dout_valid (dout_valid)
`endif
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic edge_then_sample();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // 1. reset low from t=0, no clock edge yet
    reset = 1'b0;
    din   = 8'd10;
    load  = 1'b0;
    #10;
    check8("reset_immediate", dout, 8'd0);
`ifdef DATA_REGISTER_VALID_EN
    check1("valid_after_reset", dout_valid, 1'b0);
`endif

    // edge during reset with load=1 is ignored
    load = 1'b1;
    din  = 8'h55;
    edge_then_sample();
    check8("load_ignored_in_reset", dout, 8'd0);

    // 2. release reset, hold edge
    @(negedge clock);
    reset = 1'b1;
    load  = 1'b0;
    din   = 8'd10;
    edge_then_sample();
    check8("hold_after_release", dout, 8'd0);
`ifdef DATA_REGISTER_VALID_EN
    check1("valid_hold_no_load", dout_valid, 1'b0);
`endif

    // 3. load 10, not visible before edge
    @(negedge clock);
    load = 1'b1;
    din  = 8'd10;
    #1;
    check8("no_change_before_edge", dout, 8'd0);
`ifdef DATA_REGISTER_VALID_EN
    check1("valid_not_before_edge", dout_valid, 1'b0);
`endif
    edge_then_sample();
    check8("load_10", dout, 8'd10);
`ifdef DATA_REGISTER_VALID_EN
    check1("valid_first_load", dout_valid, 1'b1);
`endif

    // 4. hold with din=3, then load it
    @(negedge clock);
    load = 1'b0;
    din  = 8'd3;
    edge_then_sample();
    check8("hold_10", dout, 8'd10);
`ifdef DATA_REGISTER_VALID_EN
    check1("valid_sticky", dout_valid, 1'b1);
`endif

    // din wiggle between edges has no effect
    #20;
    din = 8'hAA;
    #20;
    check8("din_between_edges", dout, 8'd10);

    @(negedge clock);
    load = 1'b1;
    din  = 8'd3;
    edge_then_sample();
    check8("load_3", dout, 8'd3);

    // full-width values
    @(negedge clock);
    din = 8'hFF;
    edge_then_sample();
    check8("load_ff", dout, 8'hFF);
    @(negedge clock);
    din = 8'h80;
    edge_then_sample();
    check8("load_80", dout, 8'h80);

    // 5. reset drops mid-cycle with a load pending
    @(negedge clock);
    din  = 8'h5A;
    load = 1'b1;
    #20;
    reset = 1'b0;
    #1;
    check8("reset_mid_cycle", dout, 8'd0);
`ifdef DATA_REGISTER_VALID_EN
    check1("valid_cleared_by_reset", dout_valid, 1'b0);
`endif
    edge_then_sample();
    check8("reset_hold_edge1", dout, 8'd0);
    edge_then_sample();
    check8("reset_hold_edge2", dout, 8'd0);
`ifdef DATA_REGISTER_VALID_EN
    check1("valid_stays_low_in_reset", dout_valid, 1'b0);
`endif

    // release again: first edge follows the load rule
    @(negedge clock);
    reset = 1'b1;
    din   = 8'h3C;
    edge_then_sample();
    check8("first_edge_after_release_loads", dout, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
